// File: rtl/memory_regfile_pkg.sv
// Shared constants and the select-width helper for the small register-file memory.
// Imported by the word register and the top level.
package memory_regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 2;

  // A 2-word store still needs one select bit, so clamp the width to at least 1.
  function automatic int sel_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/memory_word_reg.sv
// One storage word: WIDTH-bit register with synchronous reset and a load enable.
// Reset wins over load.
module memory_word_reg
  import memory_regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/memory_regfile.sv
// DEPTH x WIDTH register file: one write port and one combinational read port sharing sel.
// Out-of-range selects (non-power-of-two DEPTH) ignore writes and read as zero.
module memory_regfile
  import memory_regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int SEL_W = sel_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic             write,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic             in_range;
  logic [DEPTH-1:0] load_en;
  logic [WIDTH-1:0] word_q [DEPTH];

  assign in_range = (32'(sel) < 32'(DEPTH));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      assign load_en[gi] = write && in_range && (sel == SEL_W'(gi));

      memory_word_reg #(
        .WIDTH(WIDTH)
      ) u_word (
        .clk   (clk),
        .rst   (rst),
        .load_i(load_en[gi]),
        .data_i(dataIn),
        .data_o(word_q[gi])
      );
    end
  endgenerate

  // No match leaves the zero default, which covers out-of-range selects.
  always_comb begin
    dataOut = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == SEL_W'(i)) begin
        dataOut = word_q[i];
      end
    end
  end

  // An unknown select or enable would otherwise fall through the decode as a silent no-op.
  a_ctrl_known: assert property (@(posedge clk) disable iff (rst) !$isunknown({sel, write}));

endmodule

// File: tb/tb_memory_regfile.sv
// Directed bench for memory_regfile: a 2-word default instance and a 3-word instance.
// Stimulus queues expected read data; a monitor pops and compares on each sample strobe.
module tb_memory_regfile;

  logic        clk;
  logic        rst_a, write_a;
  logic        sel_a;
  logic [15:0] din_a, dout_a;
  logic        rst_b, write_b;
  logic [1:0]  sel_b;
  logic [15:0] din_b, dout_b;

  typedef struct {
    bit          dut_b;
    logic [15:0] exp;
    string       tag;
  } exp_t;

  exp_t queue_q[$];
  int   checks;
  int   errors;
  event sample_ev;

  memory_regfile u_dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .sel    (sel_a),
    .write  (write_a),
    .dataIn (din_a),
    .dataOut(dout_a)
  );

  memory_regfile #(
    .WIDTH(16),
    .DEPTH(3)
  ) u_dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .sel    (sel_b),
    .write  (write_b),
    .dataIn (din_b),
    .dataOut(dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each strobe presents one read result to compare against the queue head.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(sample_ev);
      if (queue_q.size() == 0) begin
        errors++;
        $display("FAIL %s: sample with empty scoreboard", "monitor");
      end else begin
        e   = queue_q.pop_front();
        act = e.dut_b ? dout_b : dout_a;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: dataOut=%h expected=%h", e.tag, act, e.exp);
        end else begin
          $display("ok   %s: dataOut=%h", e.tag, act);
        end
      end
    end
  end

  task automatic expect_a(input logic s, input logic [15:0] exp, input string tag);
    exp_t e;
    sel_a = s;
    e.dut_b = 1'b0; e.exp = exp; e.tag = tag;
    queue_q.push_back(e);
    #1 -> sample_ev;
    #1;
  endtask

  task automatic expect_b(input logic [1:0] s, input logic [15:0] exp, input string tag);
    exp_t e;
    sel_b = s;
    e.dut_b = 1'b1; e.exp = exp; e.tag = tag;
    queue_q.push_back(e);
    #1 -> sample_ev;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a_word(input logic s, input logic [15:0] d);
    sel_a = s; din_a = d; write_a = 1'b1;
    edge_step();
    write_a = 1'b0;
  endtask

  task automatic write_b_word(input logic [1:0] s, input logic [15:0] d);
    sel_b = s; din_b = d; write_b = 1'b1;
    edge_step();
    write_b = 1'b0;
  endtask

  initial begin
    int wait_cycles;
    checks = 0; errors = 0;
    rst_a = 1'b1; write_a = 1'b0; sel_a = 1'b0; din_a = '0;
    rst_b = 1'b1; write_b = 1'b0; sel_b = 2'd0; din_b = '0;
    edge_step();
    edge_step();
    rst_a = 1'b0; rst_b = 1'b0;

    expect_a(1'b0, 16'h0000, "reset_state_w0");
    expect_a(1'b1, 16'h0000, "reset_state_w1");

    // Fill both words, then reset clears them.
    write_a_word(1'b0, 16'h1111);
    write_a_word(1'b1, 16'h2222);
    expect_a(1'b0, 16'h1111, "prefill_w0");
    expect_a(1'b1, 16'h2222, "prefill_w1");
    rst_a = 1'b1;
    edge_step();
    rst_a = 1'b0;
    expect_a(1'b0, 16'h0000, "reset_clears_w0");
    expect_a(1'b1, 16'h0000, "reset_clears_w1");

    write_a_word(1'b0, 16'h1234);
    expect_a(1'b0, 16'h1234, "write_w0");
    write_a_word(1'b1, 16'hABCD);
    expect_a(1'b1, 16'hABCD, "write_w1");
    expect_a(1'b0, 16'h1234, "w0_undisturbed");

    // Read mux follows sel with no clock edge between samples.
    edge_step();
    expect_a(1'b0, 16'h1234, "mux_sel0");
    expect_a(1'b1, 16'hABCD, "mux_sel1");
    expect_a(1'b0, 16'h1234, "mux_sel0_again");

    // Reset has priority over a simultaneous write.
    rst_a = 1'b1; write_a = 1'b1; sel_a = 1'b0; din_a = 16'hFFFF;
    edge_step();
    rst_a = 1'b0; write_a = 1'b0;
    expect_a(1'b0, 16'h0000, "rst_over_write_w0");
    expect_a(1'b1, 16'h0000, "rst_over_write_w1");

    // Same-word write: old value before the edge, new value after.
    write_a_word(1'b1, 16'h1111);
    write_a = 1'b1; din_a = 16'h5A5A;
    expect_a(1'b1, 16'h1111, "rdw_before_edge");
    edge_step();
    write_a = 1'b0;
    expect_a(1'b1, 16'h5A5A, "rdw_after_edge");

    // write=0 holds even with new data presented.
    sel_a = 1'b0; din_a = 16'hFFFF;
    edge_step();
    expect_a(1'b0, 16'h0000, "hold_no_write");

    // Non-power-of-two depth: sel=3 is out of range.
    write_b_word(2'd0, 16'h0A0A);
    write_b_word(2'd1, 16'h0B0B);
    write_b_word(2'd2, 16'h0C0C);
    write_b_word(2'd3, 16'hBEEF);
    expect_b(2'd0, 16'h0A0A, "d3_w0");
    expect_b(2'd1, 16'h0B0B, "d3_w1");
    expect_b(2'd2, 16'h0C0C, "d3_w2");
    expect_b(2'd3, 16'h0000, "d3_oor_read");

    wait_cycles = 0;
    while (queue_q.size() != 0 && wait_cycles < 100) begin
      edge_step();
      wait_cycles++;
    end
    if (queue_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d entries left, expected 0", "drain", queue_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
